// File: rtl/accu_pkg.sv
// Shared types and helpers for the streaming accumulator family.
package accu_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StAccum
  } accu_state_e;

  // Width of a field that must hold 0..max_n inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_n);
    return $clog2(max_n + 1);
  endfunction

  // Sum width wide enough that max_n full-scale beats never wrap.
  function automatic int unsigned out_width(input int unsigned data_w, input int unsigned max_n);
    return data_w + $clog2(max_n);
  endfunction

  // A zero length means single-beat groups; oversize lengths saturate at max_n.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_n);
    if (len == 0) begin
      return 1;
    end else if (len > max_n) begin
      return max_n;
    end
    return len;
  endfunction

endpackage

// File: rtl/accu_grp.sv
// Streaming group accumulator: sums a programmable number of accepted beats and
// emits one widened sum per group through a single-entry valid/ready output slot.
module accu_grp
  import accu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MAX_N  = 16,
  parameter bit          SIGNED = 1'b0,
  parameter int unsigned CNT_W  = cnt_width(MAX_N),
  parameter int unsigned OUT_W  = out_width(DATA_W, MAX_N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [CNT_W-1:0]  group_len,
  input  logic              flush,
  output logic [OUT_W-1:0]  data_out,
  output logic [CNT_W-1:0]  cnt_out,
  output logic              valid_out,
  input  logic              ready_out
);

  accu_state_e      r_state;
  logic [OUT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_len;
  logic [OUT_W-1:0] r_data_out;
  logic [CNT_W-1:0] r_cnt_out;
  logic             r_valid_out;

  logic             w_ready_in;
  logic             w_accept;
  logic [OUT_W-1:0] w_ext;
  logic [CNT_W-1:0] w_len;
  logic [OUT_W-1:0] w_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_last;
  logic             w_flush_now;
  logic             w_emit;

  // Datapath and completion decode for the current cycle.
  always_comb begin
    // The slot frees in the same cycle it is taken, so no bubble between groups.
    w_ready_in = !r_valid_out || ready_out;
    w_accept   = valid_in && w_ready_in;

    if (SIGNED) begin
      w_ext = {{(OUT_W - DATA_W){data_in[DATA_W-1]}}, data_in};
    end else begin
      w_ext = {{(OUT_W - DATA_W){1'b0}}, data_in};
    end

    // Length is only captured on the first beat; mid-group changes are ignored.
    if (r_state == StIdle) begin
      w_len = CNT_W'(clamp_len(32'(group_len), MAX_N));
    end else begin
      w_len = r_len;
    end

    w_sum       = w_accept ? (r_acc + w_ext) : r_acc;
    w_cnt_next  = r_count + CNT_W'(w_accept);
    w_last      = w_accept && (w_cnt_next == w_len);
    // Flush only counts when the slot can take a result and something was summed.
    w_flush_now = w_ready_in && flush && (w_cnt_next != '0);
    w_emit      = w_last || w_flush_now;
  end

  // Group FSM, accumulator and registered output slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_acc       <= '0;
      r_count     <= '0;
      r_len       <= '0;
      r_data_out  <= '0;
      r_cnt_out   <= '0;
      r_valid_out <= 1'b0;
    end else begin
      if (w_emit) begin
        r_data_out  <= w_sum;
        r_cnt_out   <= w_cnt_next;
        r_valid_out <= 1'b1;
        r_acc       <= '0;
        r_count     <= '0;
        r_len       <= w_len;
        r_state     <= StIdle;
      end else begin
        if (r_valid_out && ready_out) begin
          r_valid_out <= 1'b0;
        end
        if (w_accept) begin
          r_acc   <= w_sum;
          r_count <= w_cnt_next;
          r_len   <= w_len;
          r_state <= StAccum;
        end
      end
    end
  end

  assign ready_in  = w_ready_in;
  assign data_out  = r_data_out;
  assign cnt_out   = r_cnt_out;
  assign valid_out = r_valid_out;

endmodule

// File: tb/tb_accu_grp.sv
// Bench for accu_grp: an unsigned and a signed instance share one stimulus stream
// and are checked every cycle against a group-level model, plus literal results.
module tb_accu_grp;

  localparam int unsigned DataW = 8;
  localparam int unsigned MaxN  = 16;
  localparam int unsigned CntW  = 5;
  localparam int unsigned OutW  = 12;

  logic             clk;
  logic             rst_n;
  logic [DataW-1:0] data_in;
  logic             valid_in;
  logic [CntW-1:0]  group_len;
  logic             flush;
  logic             ready_out;

  logic             ready_in_u, ready_in_s;
  logic [OutW-1:0]  data_out_u, data_out_s;
  logic [CntW-1:0]  cnt_out_u, cnt_out_s;
  logic             valid_out_u, valid_out_s;

  int n_cmp;
  int n_err;

  accu_grp #(.DATA_W(DataW), .MAX_N(MaxN), .SIGNED(1'b0)) u_dut_u (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in_u),
    .group_len (group_len),
    .flush     (flush),
    .data_out  (data_out_u),
    .cnt_out   (cnt_out_u),
    .valid_out (valid_out_u),
    .ready_out (ready_out)
  );

  accu_grp #(.DATA_W(DataW), .MAX_N(MaxN), .SIGNED(1'b1)) u_dut_s (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in_s),
    .group_len (group_len),
    .flush     (flush),
    .data_out  (data_out_s),
    .cnt_out   (cnt_out_s),
    .valid_out (valid_out_s),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Group-level model: integer sums, beat count and a one-deep result slot.
  int m_su, m_ss, m_cnt, m_len;
  int m_du, m_ds, m_dc;
  bit m_vout;
  bit m_rdy, m_acc;

  initial begin
    m_su = 0; m_ss = 0; m_cnt = 0; m_len = 0;
    m_du = 0; m_ds = 0; m_dc = 0; m_vout = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_su = 0; m_ss = 0; m_cnt = 0; m_len = 0;
        m_du = 0; m_ds = 0; m_dc = 0; m_vout = 0;
      end else begin
        m_rdy = !m_vout || ready_out;
        m_acc = valid_in && m_rdy;
        if (m_vout && ready_out) m_vout = 0;
        if (m_acc) begin
          if (m_cnt == 0) begin
            m_len = (group_len == 0) ? 1 : ((int'(group_len) > MaxN) ? MaxN : int'(group_len));
          end
          m_su += int'(data_in);
          m_ss += int'($signed(data_in));
          m_cnt++;
        end
        if (m_rdy && ((m_acc && m_cnt == m_len) || (flush && m_cnt > 0))) begin
          m_vout = 1;
          m_du = m_su; m_ds = m_ss; m_dc = m_cnt;
          m_su = 0; m_ss = 0; m_cnt = 0;
        end
      end
    end
  end

  // Per-cycle compare against the model, and capture of transferred results.
  int q_u[$], q_s[$], q_c[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("valid_out_u", int'(valid_out_u), int'(m_vout));
      chk("valid_out_s", int'(valid_out_s), int'(m_vout));
      chk("ready_in_u", int'(ready_in_u), int'(!m_vout || ready_out));
      chk("ready_in_s", int'(ready_in_s), int'(!m_vout || ready_out));
      if (m_vout) begin
        chk("data_out_u", int'(data_out_u), m_du & 'hFFF);
        chk("data_out_s", int'(data_out_s), m_ds & 'hFFF);
        chk("cnt_out_u", int'(cnt_out_u), m_dc);
        chk("cnt_out_s", int'(cnt_out_s), m_dc);
      end
      if (valid_out_u && ready_out) begin
        q_u.push_back(int'(data_out_u));
        q_s.push_back(int'(data_out_s));
        q_c.push_back(int'(cnt_out_u));
      end
    end
  end

  // Present one beat and hold it until the DUT takes it.
  task automatic send(input int d, input bit fl);
    bit taken;
    data_in  = DataW'(d);
    valid_in = 1'b1;
    flush    = fl;
    taken    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ready_in_u) begin
        taken = 1'b1;
        break;
      end
    end
    if (!taken) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic drain();
    ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop(input string name, input int exp_u, input int exp_s, input int exp_c);
    if (q_u.size() == 0) begin
      chk({name, "_present"}, 0, 1);
    end else begin
      chk({name, "_sum_u"}, q_u.pop_front(), exp_u);
      chk({name, "_sum_s"}, q_s.pop_front(), exp_s);
      chk({name, "_cnt"}, q_c.pop_front(), exp_c);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; data_in = '0; valid_in = 1'b0; group_len = 5'd4; flush = 1'b0;
    ready_out = 1'b1;
    #12;
    chk("rst_data", int'(data_out_u), 0);
    chk("rst_cnt", int'(cnt_out_u), 0);
    chk("rst_valid", int'(valid_out_u), 0);
    chk("rst_ready_in", int'(ready_in_u), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full groups of four, back to back.
    group_len = 5'd4;
    send(1, 0); send(2, 0); send(3, 0); send(14, 0);
    chk("t1_latency_valid", int'(valid_out_u), 1);
    chk("t1_latency_data", int'(data_out_u), 20);
    send(5, 0); send(2, 0); send(103, 0); send(4, 0);
    send(5, 0); send(6, 0); send(3, 0); send(54, 0);
    drain();
    pop("t1_a", 20, 20, 4);
    pop("t1_b", 114, 114, 4);
    pop("t1_c", 68, 68, 4);

    // Downstream stall holds the first result and blocks input.
    group_len = 5'd2;
    ready_out = 1'b0;
    send(10, 0); send(20, 0);
    fork
      begin
        send(30, 0); send(40, 0);
      end
      begin
        repeat (3) begin
          @(negedge clk);
          chk("t2_stall_ready_in", int'(ready_in_u), 0);
          chk("t2_stall_data", int'(data_out_u), 30);
        end
        @(posedge clk);
        #1;
        ready_out = 1'b1;
      end
    join
    drain();
    pop("t2_a", 30, 30, 2);
    pop("t2_b", 70, 70, 2);

    // Early flush of a partial group, then a flush with nothing pending.
    group_len = 5'd8;
    send(7, 0); send(8, 0); send(9, 1);
    drain();
    pop("t3_flush", 24, 24, 3);
    flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    flush = 1'b0;
    drain();
    chk("t3_empty_flush_valid", int'(valid_out_u), 0);
    chk("t3_empty_flush_none", q_u.size(), 0);

    // Two's-complement sum: -128 + -128 + 5 = -251 = 12'hF05.
    group_len = 5'd3;
    send(8'h80, 0); send(8'h80, 0); send(5, 0);
    drain();
    pop("t4_signed", 261, 12'hF05, 3);

    // Length clamping at both ends.
    group_len = 5'd0;
    send(3, 0); send(4, 0);
    drain();
    pop("t5_len0_a", 3, 3, 1);
    pop("t5_len0_b", 4, 4, 1);
    group_len = 5'd31;
    for (int i = 0; i < 16; i++) send(255, 0);
    drain();
    pop("t5_clamp", 4080, 12'hFF0, 16);

    // Reset in the middle of a group discards the partial sum.
    group_len = 5'd4;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    drain();
    pop("t6_pre", 10, 10, 4);
    send(9, 0); send(9, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data", int'(data_out_u), 0);
    chk("t6_rst_cnt", int'(cnt_out_u), 0);
    chk("t6_rst_valid", int'(valid_out_u), 0);
    chk("t6_rst_ready_in", int'(ready_in_u), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    drain();
    pop("t6_post", 4, 4, 4);
    chk("t6_no_residue", q_u.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
